fft_sram_arbiter: RTL and testbench

Single-port arbiter and sequencer for the 512x16 on-chip FFT sample SRAM. It shares the SRAM between three requesters: the Avalon-slave loader, the FFT butterfly engine and the Avalon-master writeback DMA. Each requester uses a valid/ready command port. The block grants one access per cycle with round-robin fairness and an optional lock for burst ownership, drives the SRAM `f_*` pins from registers, and routes read data back to the issuing requester.

---
 rtl/fft_sram_pkg.sv | 22 ++
 rtl/fft_sram_arbiter_rr_priority_picker.sv | 27 ++
 rtl/fft_sram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fft_sram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sram_pkg.sv
// Shared constants and enums for the FFT sample SRAM arbiter.
package fft_sram_pkg;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int ID_W   = 2;

  // Requester identities; the value is the bit position in the request vectors.
  typedef enum logic [ID_W-1:0] {
    REQ_LOAD = 2'd0,
    REQ_FFT  = 2'd1,
    REQ_DUMP = 2'd2
  } req_id_e;

  // Arbitration FSM: open competition or exclusive burst ownership.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fft_sram_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker: the first set request at or after
// i_start (wrapping) wins, returned as a one-hot grant. i_start must be < N.
module rr_priority_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_grant
);

  logic [2*N-1:0] w_req2;
  logic [2*N-1:0] w_rot2;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_pick;
  logic [2*N-1:0] w_gnt2;

  // Rotate so the start index lands on bit 0, isolate the lowest set bit,
  // then rotate back. Doubling the vector turns the rotation into a shift.
  assign w_req2  = {i_req, i_req};
  assign w_rot2  = w_req2 >> i_start;
  assign w_rot   = w_rot2[N-1:0];
  assign w_pick  = w_rot & (-w_rot);
  assign w_gnt2  = {{N{1'b0}}, w_pick} << i_start;
  assign o_grant = w_gnt2[N-1:0] | w_gnt2[2*N-1:N];

endmodule

// File: rtl/fft_sram_arbiter.sv
// Single-port arbiter for the 512x16 FFT sample SRAM: round-robin grant with
// optional burst lock, registered SRAM pins and in-order read-data routing.
module fft_sram_arbiter
  import fft_sram_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ-1:0]        i_req_write,
  input  logic [NREQ-1:0]        i_req_lock,
  input  logic [NREQ*ADDR_W-1:0] i_req_addr,
  input  logic [NREQ*DATA_W-1:0] i_req_wdata,
  output logic [NREQ-1:0]        o_req_ready,
  output logic [NREQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]      o_rsp_rdata,
  output logic                   o_f_rden,
  output logic                   o_f_wren,
  output logic [ADDR_W-1:0]      o_f_address,
  output logic [DATA_W-1:0]      o_f_data,
  input  logic [DATA_W-1:0]      i_f_q,
  output logic [1:0]             o_owner,
  output logic                   o_locked,
  output logic                   o_lock_err
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_owner;
  logic [ID_W-1:0]   r_rd_id;
  logic [CNT_W-1:0]  r_idle_cnt;
  logic              r_f_rden;
  logic              r_f_wren;
  logic [ADDR_W-1:0] r_f_address;
  logic [DATA_W-1:0] r_f_data;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [ID_W-1:0]   r_tag_id [RD_LAT];

  logic [ID_W-1:0]   w_start;
  logic [NREQ-1:0]   w_owner_oh;
  logic [NREQ-1:0]   w_req_mask;
  logic [NREQ-1:0]   w_grant;
  logic              w_owner_valid;
  logic              w_hs;
  logic              w_expire;
  logic [ID_W-1:0]   w_sel_id;
  logic              w_sel_write;
  logic              w_sel_lock;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
    assign w_owner_oh[gi] = (r_owner == ID_W'(gi));
  end

  assign w_owner_valid = |(i_req_valid & w_owner_oh);
  assign w_start       = (r_last_grant == ID_W'(NREQ - 1)) ? '0 : r_last_grant + ID_W'(1);
  // While locked the same picker is reused with everyone but the owner masked off.
  assign w_req_mask    = (r_state == LOCKED) ? (i_req_valid & w_owner_oh) : i_req_valid;
  // An idle owner is only forced out on the cycle its count would hit the limit;
  // an owner with valid high is always granted, so a handshake always wins.
  assign w_expire      = (r_state == LOCKED) && !w_owner_valid &&
                         (r_idle_cnt == CNT_W'(LOCK_MAX - 1));

  rr_priority_picker #(
    .N     (NREQ),
    .IDX_W (ID_W)
  ) u_picker (
    .i_req   (w_req_mask),
    .i_start (w_start),
    .o_grant (w_grant)
  );

  assign w_hs = |w_grant;

  // Route the winning requester's command fields.
  always_comb begin
    w_sel_id    = '0;
    w_sel_write = 1'b0;
    w_sel_lock  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_id    = ID_W'(k);
        w_sel_write = i_req_write[k];
        w_sel_lock  = i_req_lock[k];
        w_sel_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = i_req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // FSM next state: enter LOCKED on a locking transfer, leave on an unlocking
  // transfer by the owner or on idle timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB:     if (w_hs && w_sel_lock) w_state_next = LOCKED;
      LOCKED:  if ((w_hs && !w_sel_lock) || w_expire) w_state_next = ARB;
      default: w_state_next = ARB;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ARB;
    else       r_state <= w_state_next;
  end

  // Pointer, owner, idle counter and the registered SRAM command.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= REQ_DUMP;
      r_owner      <= '0;
      r_rd_id      <= '0;
      r_idle_cnt   <= '0;
      r_f_rden     <= 1'b0;
      r_f_wren     <= 1'b0;
      r_f_address  <= '0;
      r_f_data     <= '0;
    end else begin
      r_f_rden <= w_hs && !w_sel_write;
      r_f_wren <= w_hs && w_sel_write;
      if (w_hs) begin
        r_f_address  <= w_sel_addr;
        r_f_data     <= w_sel_wdata;
        r_rd_id      <= w_sel_id;
        r_last_grant <= w_sel_id;
      end else if (w_expire) begin
        r_last_grant <= r_owner;
      end
      if (w_hs && w_sel_lock) r_owner <= w_sel_id;
      if (r_state == ARB || w_hs || w_expire) r_idle_cnt <= '0;
      else if (!w_owner_valid)                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end
  end

  // Read tags follow the SRAM latency so data returns to its issuer in order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_vld[0] <= r_f_rden;
      r_tag_id[0]  <= r_rd_id;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign o_rsp_valid[gi] = r_tag_vld[RD_LAT-1] && (r_tag_id[RD_LAT-1] == ID_W'(gi));
  end

  assign o_req_ready = w_grant;
  assign o_rsp_rdata = i_f_q;
  assign o_f_rden    = r_f_rden;
  assign o_f_wren    = r_f_wren;
  assign o_f_address = r_f_address;
  assign o_f_data    = r_f_data;
  assign o_owner     = r_owner;
  assign o_locked    = (r_state == LOCKED);
  assign o_lock_err  = w_expire;

endmodule

// File: tb/tb_fft_sram_arbiter.sv
// Scoreboard bench for fft_sram_arbiter with a behavioural 1-cycle SRAM.
module tb_fft_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0, req_write = '0, req_lock = '0;
  logic [26:0] req_addr = '0;
  logic [47:0] req_wdata = '0;
  logic [2:0]  req_ready, rsp_valid;
  logic [15:0] rsp_rdata, f_data, f_q;
  logic        f_rden, f_wren, locked, lock_err;
  logic [8:0]  f_address;
  logic [1:0]  owner;

  fft_sram_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write(req_write),
    .i_req_lock(req_lock), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_f_rden(f_rden), .o_f_wren(f_wren), .o_f_address(f_address), .o_f_data(f_data),
    .i_f_q(f_q), .o_owner(owner), .o_locked(locked), .o_lock_err(lock_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 37 + 4660);
  endfunction

  // Behavioural SRAM, one cycle read latency, contents default to pat().
  logic [15:0] sram [int];
  always @(posedge clk) begin
    if (f_wren) sram[int'(f_address)] = f_data;
    if (f_rden) f_q <= sram.exists(int'(f_address)) ? sram[int'(f_address)] : pat(int'(f_address));
  end

  // Scoreboard state.
  typedef struct { int id; logic [15:0] data; int due; } rsp_t;
  rsp_t        rsp_q[$];
  logic [15:0] ref_mem [int];
  int          gnt_log[$];
  int          gnt_cnt[3] = '{0, 0, 0};
  int          rsp_cnt[3] = '{0, 0, 0};
  logic [15:0] last_rdata = '0;
  int          wren_cnt = 0;
  bit          prev_hs = 0, prev_wr = 0;
  logic [8:0]  prev_addr = '0;
  logic [15:0] prev_data = '0;

  // Monitor: check last cycle's command on the pins, due responses, grant
  // legality, then record this cycle's handshake.
  always @(negedge clk) begin
    logic [2:0] hs;
    if (rst) begin
      check("rst_rden", f_rden, 0);
      check("rst_wren", f_wren, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_lock_err", lock_err, 0);
      check("rst_locked", locked, 0);
      check("rst_addr", f_address, 0);
      check("rst_data", f_data, 0);
      check("rst_owner", owner, 0);
      rsp_q.delete();
      prev_hs = 0;
    end else begin
      check("f_rden", f_rden, prev_hs && !prev_wr);
      check("f_wren", f_wren, prev_hs && prev_wr);
      if (prev_hs) check("f_address", f_address, prev_addr);
      if (prev_hs && prev_wr) check("f_data", f_data, prev_data);
      if (f_wren) wren_cnt++;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        check("rsp_valid", rsp_valid, 32'(1) << rsp_q[0].id);
        check("rsp_rdata", rsp_rdata, rsp_q[0].data);
        rsp_q.pop_front();
      end else begin
        check("rsp_idle", rsp_valid, 0);
      end
      for (int k = 0; k < 3; k++) if (rsp_valid[k]) begin rsp_cnt[k]++; last_rdata = rsp_rdata; end
      check("ready_onehot", $onehot0(req_ready), 1);
      check("ready_subset", req_ready & ~req_valid, 0);
      hs = req_ready & req_valid;
      prev_hs = 0;
      for (int k = 0; k < 3; k++) begin
        if (hs[k]) begin
          int a;
          a = int'(req_addr[k*9 +: 9]);
          prev_hs = 1;
          prev_wr = req_write[k];
          prev_addr = req_addr[k*9 +: 9];
          prev_data = req_wdata[k*16 +: 16];
          gnt_log.push_back(k);
          gnt_cnt[k]++;
          if (req_write[k]) ref_mem[a] = req_wdata[k*16 +: 16];
          else rsp_q.push_back('{k, ref_mem.exists(a) ? ref_mem[a] : pat(a), cyc + 2});
          $display("txn cyc=%0d req=%0d %s addr=0x%03h data=0x%04h lock=%0d", cyc, k,
                   req_write[k] ? "WR" : "RD", req_addr[k*9 +: 9], req_wdata[k*16 +: 16], req_lock[k]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input bit v, input bit wr, input bit lk,
                       input logic [8:0] a, input logic [15:0] d);
    req_valid[id] = v;
    req_write[id] = wr;
    req_lock[id]  = lk;
    req_addr[id*9 +: 9]    = a;
    req_wdata[id*16 +: 16] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    int s, base, n, c;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Phase 1: 256 back-to-back loader writes.
    wren_cnt = 0;
    s = gnt_log.size();
    for (int a = 0; a < 256; a++) begin
      drive(0, 1, 1, 0, 9'(a), 16'h0100);
      step();
    end
    idle_all();
    repeat (3) step();
    check("p1_wren_cnt", wren_cnt, 256);
    check("p1_grants", gnt_log.size() - s, 256);

    // Phase 2: all three read continuously after reset -> 0,1,2,0,...
    do_reset();
    s = gnt_log.size();
    for (int i = 0; i < 3; i++) drive(i, 1, 0, 0, 9'(256 + i * 17), '0);
    repeat (12) step();
    idle_all();
    repeat (4) step();
    if (gnt_log.size() - s < 12) check("p2_len", gnt_log.size() - s, 12);
    else for (int k = 0; k < 12; k++) check("p2_order", gnt_log[s + k], k % 3);

    // Phase 3: FFT burst of 8 locked reads plus one unlocking read.
    base = gnt_cnt[1];
    s = gnt_log.size();
    drive(1, 1, 0, 1, 9'h040, '0);
    step();
    n = 0;
    while (gnt_cnt[1] - base < 9 && n < 40) begin
      c = gnt_cnt[1] - base;
      drive(0, 1, 0, 0, 9'h050, '0);
      drive(2, 1, 0, 0, 9'h060, '0);
      drive(1, 1, 0, c < 8, 9'(32'h40 + c), '0);
      if (c >= 1 && c <= 8) begin
        check("p3_locked", locked, 1);
        check("p3_owner", owner, 1);
      end
      step();
      n++;
    end
    check("p3_budget", n < 40, 1);
    drive(1, 0, 0, 0, '0, '0);
    step();
    idle_all();
    repeat (4) step();
    if (gnt_log.size() - s < 10) check("p3_len", gnt_log.size() - s, 10);
    else begin
      for (int k = 0; k < 9; k++) check("p3_fft_only", gnt_log[s + k], 1);
      check("p3_next_dump", gnt_log[s + 9], 2);
    end

    // Phase 4: FFT locks then goes idle; forced release after 64 idle cycles.
    drive(1, 1, 0, 1, 9'h070, '0);
    @(negedge clk);
    check("p4_lock_hs", req_ready, 3'b010);
    step();
    drive(1, 0, 0, 0, '0, '0);
    drive(0, 1, 0, 0, 9'h020, '0);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      check("p4_lock_err", lock_err, k == 64);
      check("p4_locked", locked, k <= 64);
      check("p4_load_ready", req_ready[0], k >= 65);
      step();
    end
    idle_all();
    repeat (4) step();

    // Phase 5: reset during the f_rden cycle of a writeback read.
    drive(2, 1, 0, 0, 9'h1FF, '0);
    step();
    idle_all();
    check("p5_rden_cycle", f_rden, 1);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) drive(i, 1, 0, 0, 9'(i + 8), '0);
    @(negedge clk);
    check("p5_first_grant", req_ready, 3'b001);
    step();
    idle_all();
    repeat (4) step();

    // Phase 6: writeback write then FFT read of the same address.
    base = rsp_cnt[1];
    drive(2, 1, 1, 0, 9'h010, 16'hA5A5);
    step();
    drive(2, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 0, 9'h010, '0);
    step();
    idle_all();
    repeat (4) step();
    check("p6_rsp_count", rsp_cnt[1] - base, 1);
    check("p6_rdata", last_rdata, 16'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
